// File: rtl/sfft_pkg.sv
// Shared constants, twiddle tables and types for the sliding-window FFT engine.
package sfft_pkg;

  localparam int unsigned NFFT                      = 32;
  localparam int unsigned nFFT                      = 5;
  localparam int unsigned SFFT_INPUT_WIDTH          = 24;
  localparam int unsigned SFFT_OUTPUT_WIDTH         = 32;
  localparam int unsigned SFFT_FIXED_POINT_ACCURACY = 7;

  localparam int unsigned TW_W    = 9;
  localparam int unsigned NTW     = NFFT / 2;
  localparam int unsigned STAGE_W = 3;
  localparam int unsigned BFLY_W  = nFFT - 1;

  // W^k = cos - j*sin, scaled by 2^7 and rounded to nearest
  localparam logic signed [TW_W-1:0] TW_COS [NTW] = '{
    9'sd128,  9'sd126,  9'sd118,  9'sd106,  9'sd91,   9'sd71,   9'sd49,   9'sd25,
    9'sd0,   -9'sd25,  -9'sd49,  -9'sd71,  -9'sd91,  -9'sd106, -9'sd118, -9'sd126
  };

  localparam logic signed [TW_W-1:0] TW_SIN [NTW] = '{
    9'sd0,    9'sd25,   9'sd49,   9'sd71,   9'sd91,   9'sd106,  9'sd118,  9'sd126,
    9'sd128,  9'sd126,  9'sd118,  9'sd106,  9'sd91,   9'sd71,   9'sd49,   9'sd25
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STAGE,
    ST_MAG,
    ST_COMMIT
  } state_t;

  typedef struct packed {
    logic signed [SFFT_OUTPUT_WIDTH-1:0] re;
    logic signed [SFFT_OUTPUT_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic [nFFT-1:0] bit_rev(input logic [nFFT-1:0] v);
    logic [nFFT-1:0] r;
    for (int i = 0; i < nFFT; i++) r[i] = v[nFFT-1-i];
    return r;
  endfunction

endpackage

// File: rtl/sfft_butterfly.sv
// Combinational radix-2 DIT butterfly: (a + W*b, a - W*b), product scaled down by 2^7.
module sfft_butterfly
  import sfft_pkg::*;
(
  input  cplx_t                   a,
  input  cplx_t                   b,
  input  logic signed [TW_W-1:0]  w_cos,
  input  logic signed [TW_W-1:0]  w_sin,
  output cplx_t                   sum_c,
  output cplx_t                   diff_c
);

  localparam int unsigned DW = SFFT_OUTPUT_WIDTH;
  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0] br, bi, wc, ws;
  logic signed [DW-1:0] t_re, t_im;

  // b * (cos - j*sin), truncated after the shift; sums wrap at DW bits
  always_comb begin
    br   = PW'(signed'(b.re));
    bi   = PW'(signed'(b.im));
    wc   = PW'(w_cos);
    ws   = PW'(w_sin);
    t_re = DW'((br * wc + bi * ws) >>> SFFT_FIXED_POINT_ACCURACY);
    t_im = DW'((bi * wc - br * ws) >>> SFFT_FIXED_POINT_ACCURACY);

    sum_c.re  = a.re + t_re;
    sum_c.im  = a.im + t_im;
    diff_c.re = a.re - t_re;
    diff_c.im = a.im - t_im;
  end

endmodule

// File: rtl/sfft_pipeline.sv
// Sliding-window 32-point FFT: window shift register, iterated butterfly over a
// work RAM, magnitude pass into a shadow buffer and a guarded double-buffer swap.
module sfft_pipeline
  import sfft_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic signed [SFFT_INPUT_WIDTH-1:0]  SampleAmplitudeIn,
  input  logic                                advanceSignal,
  input  logic                                OutputBeingRead,
  input  logic [nFFT-1:0]                     output_address,
  output logic [SFFT_OUTPUT_WIDTH-1:0]        SFFT_OutReal,
  output logic signed [SFFT_OUTPUT_WIDTH-1:0] Output_Why,
  output logic                                OutputValid,
  output logic                                outputReadError
);

  localparam int unsigned DW = SFFT_OUTPUT_WIDTH;
  localparam int unsigned FP = SFFT_FIXED_POINT_ACCURACY;

  localparam logic [nFFT-1:0]    LAST_IDX   = nFFT'(NFFT - 1);
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(nFFT - 1);
  localparam logic [BFLY_W-1:0]  LAST_BFLY  = BFLY_W'(NTW - 1);

  state_t state, state_nx;

  logic signed [SFFT_INPUT_WIDTH-1:0] win [NFFT];
  cplx_t                              work [NFFT];
  logic [DW-1:0]                      mag_buf [2][NFFT];
  logic signed [DW-1:0]               im_buf  [2][NFFT];

  logic                bank;
  logic                pending;
  logic                blocked;
  logic [nFFT-1:0]     cnt;
  logic [STAGE_W-1:0]  stage;
  logic [BFLY_W-1:0]   bfly;

  logic                start_c, swap_c, err_c;
  logic [nFFT-1:0]     span_mask_c, j_c, top_c, bot_c;
  logic [BFLY_W-1:0]   tw_idx_c;
  cplx_t               bf_sum_c, bf_diff_c, load_c;
  logic signed [DW-1:0] re_d_c, im_d_c;
  logic [DW-1:0]       re_abs_c, im_abs_c, mag_c;

  // Sample window: shifts on every strobe regardless of engine state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NFFT; i++) win[i] <= '0;
    end else if (advanceSignal) begin
      for (int i = 0; i < NFFT - 1; i++) win[i] <= win[i+1];
      win[NFFT-1] <= SampleAmplitudeIn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start_c  = 1'b0;
    swap_c   = 1'b0;
    err_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (advanceSignal || pending) begin
          state_nx = ST_LOAD;
          start_c  = 1'b1;
        end
      end
      ST_LOAD:  if (cnt == LAST_IDX) state_nx = ST_STAGE;
      ST_STAGE: if (stage == LAST_STAGE && bfly == LAST_BFLY) state_nx = ST_MAG;
      ST_MAG:   if (cnt == LAST_IDX) state_nx = ST_COMMIT;
      ST_COMMIT: begin
        if (!OutputBeingRead) begin
          swap_c   = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          err_c = !blocked;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Butterfly pair addressing: stage s pairs entries 2^s apart, twiddle j*2^(4-s)
  always_comb begin
    span_mask_c = (nFFT'(1) << stage) - nFFT'(1);
    j_c         = nFFT'(bfly) & span_mask_c;
    top_c       = ((nFFT'(bfly) >> stage) << (stage + STAGE_W'(1))) | j_c;
    bot_c       = top_c | (nFFT'(1) << stage);
    tw_idx_c    = BFLY_W'(j_c << (STAGE_W'(nFFT - 1) - stage));
  end

  sfft_butterfly u_bfly (
    .a      (work[top_c]),
    .b      (work[bot_c]),
    .w_cos  (TW_COS[tw_idx_c]),
    .w_sin  (TW_SIN[tw_idx_c]),
    .sum_c  (bf_sum_c),
    .diff_c (bf_diff_c)
  );

  always_comb begin
    load_c.re = DW'(win[bit_rev(cnt)]) <<< FP;
    load_c.im = '0;
    re_d_c    = work[cnt].re >>> FP;
    im_d_c    = work[cnt].im >>> FP;
    re_abs_c  = re_d_c[DW-1] ? -re_d_c : re_d_c;
    im_abs_c  = im_d_c[DW-1] ? -im_d_c : im_d_c;
    mag_c     = re_abs_c + im_abs_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      stage   <= '0;
      bfly    <= '0;
      pending <= 1'b0;
      blocked <= 1'b0;
    end else begin
      if (advanceSignal && state != ST_IDLE) pending <= 1'b1;
      else if (start_c)                      pending <= 1'b0;

      if (err_c)       blocked <= 1'b1;
      else if (swap_c) blocked <= 1'b0;

      case (state)
        ST_IDLE:         cnt <= '0;
        ST_LOAD, ST_MAG: cnt <= cnt + nFFT'(1);
        ST_STAGE: begin
          bfly <= bfly + BFLY_W'(1);
          if (bfly == LAST_BFLY)
            stage <= (stage == LAST_STAGE) ? '0 : stage + STAGE_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Work RAM: bit-reversed load, then in-place butterflies
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NFFT; i++) work[i] <= '0;
    end else if (state == ST_LOAD) begin
      work[cnt] <= load_c;
    end else if (state == ST_STAGE) begin
      work[top_c] <= bf_sum_c;
      work[bot_c] <= bf_diff_c;
    end
  end

  // Output buffers: MAG only ever writes the shadow side
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NFFT; i++) begin
        mag_buf[0][i] <= '0;
        mag_buf[1][i] <= '0;
        im_buf[0][i]  <= '0;
        im_buf[1][i]  <= '0;
      end
    end else if (state == ST_MAG) begin
      mag_buf[~bank][cnt] <= mag_c;
      im_buf[~bank][cnt]  <= im_d_c;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank            <= 1'b0;
      OutputValid     <= 1'b0;
      outputReadError <= 1'b0;
      SFFT_OutReal    <= '0;
      Output_Why      <= '0;
    end else begin
      if (swap_c) begin
        bank        <= ~bank;
        OutputValid <= 1'b1;
      end
      outputReadError <= err_c;
      SFFT_OutReal    <= mag_buf[bank][output_address];
      Output_Why      <= im_buf[bank][output_address];
    end
  end

endmodule

// File: tb/tb_sfft_pipeline.sv
// Self-checking bench for sfft_pipeline against a floating-point-derived twiddle
// table and a textbook iterative DIT FFT model.
module tb_sfft_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] SampleAmplitudeIn;
  logic        advanceSignal;
  logic        OutputBeingRead;
  logic [4:0]  output_address;
  logic [31:0] SFFT_OutReal;
  logic [31:0] Output_Why;
  logic        OutputValid;
  logic        outputReadError;

  int n_cmp = 0;
  int n_bad = 0;
  int win_m [32];
  int exp_mag [32];
  int exp_im [32];
  int old_mag [32];
  int tw_c [16];
  int tw_s [16];
  int err_pulses = 0;

  sfft_pipeline dut (
    .clk               (clk),
    .reset             (reset),
    .SampleAmplitudeIn (SampleAmplitudeIn),
    .advanceSignal     (advanceSignal),
    .OutputBeingRead   (OutputBeingRead),
    .output_address    (output_address),
    .SFFT_OutReal      (SFFT_OutReal),
    .Output_Why        (Output_Why),
    .OutputValid       (OutputValid),
    .outputReadError   (outputReadError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (outputReadError === 1'b1) err_pulses++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic int brev(input int v);
    int r = 0;
    for (int b = 0; b < 5; b++) if (v[b]) r |= 1 << (4 - b);
    return r;
  endfunction

  function automatic void compute_model();
    int re_w [32];
    int im_w [32];
    int half, k, ia, ib, tr, ti, rd, id;
    longint p_re, p_im;
    for (int i = 0; i < 32; i++) begin
      re_w[i] = win_m[brev(i)] * 128;
      im_w[i] = 0;
    end
    for (int span = 2; span <= 32; span = span * 2) begin
      half = span / 2;
      for (int g = 0; g < 32; g = g + span) begin
        for (int j = 0; j < half; j++) begin
          k  = j * (32 / span);
          ia = g + j;
          ib = ia + half;
          p_re = (longint'(re_w[ib]) * longint'(tw_c[k]) + longint'(im_w[ib]) * longint'(tw_s[k])) >>> 7;
          p_im = (longint'(im_w[ib]) * longint'(tw_c[k]) - longint'(re_w[ib]) * longint'(tw_s[k])) >>> 7;
          tr = int'(p_re);
          ti = int'(p_im);
          re_w[ib] = re_w[ia] - tr;
          im_w[ib] = im_w[ia] - ti;
          re_w[ia] = re_w[ia] + tr;
          im_w[ia] = im_w[ia] + ti;
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      rd = re_w[i] >>> 7;
      id = im_w[i] >>> 7;
      exp_mag[i] = (rd < 0 ? -rd : rd) + (id < 0 ? -id : id);
      exp_im[i]  = id;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input int s);
    SampleAmplitudeIn = 24'(s);
    advanceSignal = 1'b1;
    @(negedge clk);
    advanceSignal = 1'b0;
    for (int i = 0; i < 31; i++) win_m[i] = win_m[i+1];
    win_m[31] = (s <<< 8) >>> 8;
  endtask

  task automatic set_addr(input int a);
    output_address = 5'(a);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    advanceSignal = 1'b0;
    OutputBeingRead = 1'b0;
    idle(2);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) win_m[i] = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (SFFT_OutReal !== 32'd0) begin n_bad++; $display("FAIL reset_outreal: got %0d want 0", SFFT_OutReal); end
    n_cmp++;
    if (Output_Why !== 32'd0) begin n_bad++; $display("FAIL reset_why: got %0d want 0", Output_Why); end
    n_cmp++;
    if (OutputValid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", OutputValid); end
    n_cmp++;
    if (outputReadError !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", outputReadError); end
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'd0) begin n_bad++; $display("FAIL reset_sweep[%0d]: got %0d want 0", a, SFFT_OutReal); end
    end
  endtask

  task automatic test_dc();
    for (int s = 0; s < 32; s++) begin
      strobe(100);
      if (s == 0) begin
        idle(100);
        n_cmp++;
        if (OutputValid !== 1'b0) begin n_bad++; $display("FAIL dc_valid_early: got %b want 0", OutputValid); end
        idle(50);
        n_cmp++;
        if (OutputValid !== 1'b1) begin n_bad++; $display("FAIL dc_valid_late: got %b want 1", OutputValid); end
      end else begin
        idle(150);
      end
    end
    compute_model();
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'(exp_mag[a]) || Output_Why !== 32'(exp_im[a])) begin
        n_bad++;
        $display("FAIL dc_model[%0d]: got mag %0d im %0d want mag %0d im %0d", a, SFFT_OutReal, $signed(Output_Why), exp_mag[a], exp_im[a]);
      end
      n_cmp++;
      if (a == 0 && SFFT_OutReal !== 32'd3200) begin n_bad++; $display("FAIL dc_bin0: got %0d want 3200", SFFT_OutReal); end
      else if (a != 0 && SFFT_OutReal > 32'd2) begin n_bad++; $display("FAIL dc_leak[%0d]: got %0d want <=2", a, SFFT_OutReal); end
    end
  endtask

  task automatic test_impulse();
    strobe(100);
    for (int i = 0; i < 31; i++) strobe(0);
    idle(320);
    compute_model();
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'(exp_mag[a]) || Output_Why !== 32'(exp_im[a])) begin
        n_bad++;
        $display("FAIL impulse_model[%0d]: got mag %0d im %0d want mag %0d im %0d", a, SFFT_OutReal, $signed(Output_Why), exp_mag[a], exp_im[a]);
      end
      n_cmp++;
      if (SFFT_OutReal < 32'd99 || SFFT_OutReal > 32'd101 || $signed(Output_Why) > 1 || $signed(Output_Why) < -1) begin
        n_bad++;
        $display("FAIL impulse_flat[%0d]: got mag %0d im %0d want 100+-1, im ~0", a, SFFT_OutReal, $signed(Output_Why));
      end
    end
  endtask

  task automatic test_nyquist();
    for (int i = 0; i < 32; i++) strobe((i % 2 == 0) ? 50 : -50);
    idle(320);
    compute_model();
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'(exp_mag[a])) begin
        n_bad++;
        $display("FAIL nyq_model[%0d]: got %0d want %0d", a, SFFT_OutReal, exp_mag[a]);
      end
      n_cmp++;
      if (a == 16 && SFFT_OutReal !== 32'd1600) begin n_bad++; $display("FAIL nyq_bin16: got %0d want 1600", SFFT_OutReal); end
      else if (a != 16 && SFFT_OutReal > 32'd2) begin n_bad++; $display("FAIL nyq_leak[%0d]: got %0d want <=2", a, SFFT_OutReal); end
    end
  endtask

  task automatic test_random();
    int s;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        if (r == 0) s = int'($urandom);
        else        s = int'($urandom_range(8191)) - 4096;
        strobe(s);
        idle(int'($urandom_range(3)));
      end
      idle(320);
      compute_model();
      for (int a = 0; a < 32; a++) begin
        set_addr(a);
        n_cmp++;
        if (SFFT_OutReal !== 32'(exp_mag[a]) || Output_Why !== 32'(exp_im[a])) begin
          n_bad++;
          $display("FAIL random%0d[%0d]: got mag %0d im %0d want mag %0d im %0d", r, a, SFFT_OutReal, $signed(Output_Why), exp_mag[a], exp_im[a]);
        end
      end
    end
  endtask

  task automatic test_read_conflict();
    int e0;
    for (int a = 0; a < 32; a++) old_mag[a] = exp_mag[a];
    OutputBeingRead = 1'b1;
    e0 = err_pulses;
    strobe(int'($urandom_range(2000)) - 1000);
    idle(200);
    n_cmp++;
    if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL conflict_err_pulses: got %0d want 1", err_pulses - e0); end
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'(old_mag[a])) begin
        n_bad++;
        $display("FAIL conflict_hold[%0d]: got %0d want %0d", a, SFFT_OutReal, old_mag[a]);
      end
    end
    OutputBeingRead = 1'b0;
    @(negedge clk);
    compute_model();
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'(exp_mag[a]) || Output_Why !== 32'(exp_im[a])) begin
        n_bad++;
        $display("FAIL conflict_new[%0d]: got mag %0d im %0d want mag %0d im %0d", a, SFFT_OutReal, $signed(Output_Why), exp_mag[a], exp_im[a]);
      end
    end
    n_cmp++;
    if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL conflict_err_total: got %0d want 1", err_pulses - e0); end
  endtask

  task automatic test_back_to_back();
    int e0;
    strobe(int'($urandom_range(2000)) - 1000);
    idle(9);
    strobe(int'($urandom_range(2000)) - 1000);
    idle(190);
    OutputBeingRead = 1'b1;
    e0 = err_pulses;
    idle(200);
    n_cmp++;
    if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL b2b_second_commit: got %0d blocked commits want 1", err_pulses - e0); end
    OutputBeingRead = 1'b0;
    @(negedge clk);
    compute_model();
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'(exp_mag[a]) || Output_Why !== 32'(exp_im[a])) begin
        n_bad++;
        $display("FAIL b2b_data[%0d]: got mag %0d im %0d want mag %0d im %0d", a, SFFT_OutReal, $signed(Output_Why), exp_mag[a], exp_im[a]);
      end
    end
    OutputBeingRead = 1'b1;
    e0 = err_pulses;
    idle(300);
    n_cmp++;
    if (err_pulses - e0 !== 0) begin n_bad++; $display("FAIL b2b_third_commit: got %0d blocked commits want 0", err_pulses - e0); end
    OutputBeingRead = 1'b0;
    idle(2);
  endtask

  task automatic test_abort();
    int e0;
    strobe(int'($urandom_range(2000)) + 500);
    idle(59);
    apply_reset();
    e0 = err_pulses;
    n_cmp++;
    if (OutputValid !== 1'b0) begin n_bad++; $display("FAIL abort_valid: got %b want 0", OutputValid); end
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'd0 || Output_Why !== 32'd0) begin
        n_bad++;
        $display("FAIL abort_clear[%0d]: got mag %0d im %0d want 0 0", a, SFFT_OutReal, $signed(Output_Why));
      end
    end
    idle(300);
    n_cmp++;
    if (OutputValid !== 1'b0) begin n_bad++; $display("FAIL abort_no_commit: valid got %b want 0", OutputValid); end
    n_cmp++;
    if (err_pulses - e0 !== 0) begin n_bad++; $display("FAIL abort_err: got %0d want 0", err_pulses - e0); end
    for (int a = 0; a < 32; a++) begin
      set_addr(a);
      n_cmp++;
      if (SFFT_OutReal !== 32'd0) begin n_bad++; $display("FAIL abort_late[%0d]: got %0d want 0", a, SFFT_OutReal); end
    end
  endtask

  initial begin
    real pi_r;
    pi_r = 3.14159265358979323846;
    for (int k = 0; k < 16; k++) begin
      tw_c[k] = int'(128.0 * $cos(2.0 * pi_r * real'(k) / 32.0));
      tw_s[k] = int'(128.0 * $sin(2.0 * pi_r * real'(k) / 32.0));
    end
    reset = 1'b1;
    SampleAmplitudeIn = '0;
    advanceSignal = 1'b0;
    OutputBeingRead = 1'b0;
    output_address = '0;

    test_reset();
    test_dc();
    test_impulse();
    test_nyquist();
    test_random();
    test_read_conflict();
    test_back_to_back();
    test_abort();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sfft_pipeline.md
# sfft_pipeline

Sliding-window FFT engine sitting between the audio-codec sample stream and the spectral peak finder. On each `advanceSignal` pulse it shifts one new sample into a 32-sample window, recomputes a full 32-point radix-2 FFT with one iterated butterfly, and publishes per-bin magnitudes in a double-buffered output RAM that downstream logic reads by address.

## Interface
- `NFFT`, 32: window length and bin count (power of 2).
- `nFFT`, 5: log2(NFFT); width of `output_address`.
- `SFFT_INPUT_WIDTH`, 24: sample width.
- `SFFT_OUTPUT_WIDTH`, 32: output and internal datapath width.
- `SFFT_FIXED_POINT_ACCURACY`, 7: fractional bits of twiddles and input scaling.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `SampleAmplitudeIn` in 24: signed two's-complement sample.
- `advanceSignal` in 1: one-cycle strobe; shift in sample and start a transform.
- `OutputBeingRead` in 1: high while downstream is reading the output buffer.
- `output_address` in 5: bin index 0..31 to read.
- `SFFT_OutReal` out 32: magnitude of the addressed bin.
- `Output_Why` out 32: signed imaginary part of the addressed bin (debug).
- `OutputValid` out 1: output buffer holds at least one committed transform.
- `outputReadError` out 1: one-cycle flag, commit blocked by `OutputBeingRead`.

## Operation
- Window: 32-entry shift register; x[0] oldest, x[31] newest. On `advanceSignal`=1 at a rising edge, all entries shift down and `SampleAmplitudeIn` enters x[31], whatever the engine state.
- Input scaling: sign-extend to 32 bits, shift left by 7.
- FSM: IDLE -> LOAD (32 cycles; copy window into work RAM in bit-reversed order) -> STAGE (5 stages x 16 butterflies, 1 butterfly/cycle) -> MAG (32 cycles) -> COMMIT -> IDLE.
- `advanceSignal` outside IDLE sets a pending flag. In IDLE, `advanceSignal` or pending starts LOAD and clears pending. Several strobes during one transform collapse into one rerun.
- Butterfly: decimation-in-time; twiddle W^k = round(128*cos(2πk/32)) - j*round(128*sin(2πk/32)), k=0..15, from a constant table. Complex product arithmetic-shifted right 7 (truncate). Sums wrap at 32 bits, no saturation.
- MAG: descale by arithmetic shift right 7. Result |Re|+|Im| into shadow buffer; Im stored alongside.
- COMMIT: if `OutputBeingRead`=0, swap shadow and active buffers and set `OutputValid`. Otherwise pulse `outputReadError` for one cycle and hold in COMMIT until `OutputBeingRead`=0, then swap. The active buffer never changes while `OutputBeingRead`=1.
- Read: `SFFT_OutReal`/`Output_Why` are registered reads of active[`output_address`]. Readable in any state.

## Timing
- Reset (async): window, work RAM and both output buffers cleared. FSM to IDLE, pending cleared. `SFFT_OutReal`=0, `Output_Why`=0, `OutputValid`=0, `outputReadError`=0.
- Reset mid-transform aborts it with no commit.
- Read latency: 1 cycle from `output_address` to output.
- Transform latency: COMMIT is reached 145 cycles after the `advanceSignal` edge (32+80+32+1). The swap is visible on the read port one cycle later, unless blocked by `OutputBeingRead`.
- `OutputValid` rises the cycle after the first swap and stays high until reset.
- Address wrap: 31 -> 0 is natural 5-bit wrap.

## Structure
- Shared package `sfft_pkg`: NFFT, nFFT, widths, accuracy, twiddle cos/sin constant arrays, FSM state enum, complex-sample struct.
- One sub-module `sfft_butterfly`: combinational complex butterfly (a, b, twiddle -> a+Wb, a-Wb) with the shift-7 product rule. Everything else (window, FSM, RAMs, commit logic) lives in the top module.

## Test plan
- Reset: assert `reset` for 2 cycles -> all outputs 0, `OutputValid`=0. Sweep all addresses -> `SFFT_OutReal`=0.
- DC: 32 strobes of 100, each followed by >=150 idle cycles -> bin 0 = 3200, bins 1..31 <= 2, `OutputValid`=1.
- Impulse: strobe 100 then 31 strobes of 0 (100 ends in x[0]) -> every bin = 100 ±1, `Output_Why` ≈ 0.
- Nyquist: alternating 50, -50 for 32 strobes -> bin 16 = 1600, other bins <= 2.
- Read conflict: hold `OutputBeingRead`=1 across a completion -> one-cycle `outputReadError`, outputs unchanged. Drop it -> new data one cycle after the swap.
- Overlap and abort: strobe twice 10 cycles apart -> exactly two transforms committed, and the last reflects both samples. Then assert `reset` at cycle 60 of a transform -> outputs 0, no later commit.
